bin_sched_ctrl: RTL and testbench

BIN_SCHED_CTRL -- requirements
Module: bin_sched_ctrl

---
 rtl/sat_ctrl_pkg.sv | 52 +++++
 rtl/phase_watchdog.sv | 48 ++++
 rtl/bin_sched_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_bin_sched_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : sat_ctrl_pkg
// Brief  : Shared state encoding, default widths and state classification
//          helpers for the bin-scheduling SAT controller.
// Rev    : 1.0  initial release
// ============================================================================
package sat_ctrl_pkg;

  localparam int c_BIN_W_DEF = 16;
  localparam int c_CNT_W_DEF = 32;
  localparam int c_TMO_W_DEF = 20;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_BCP     = 4'd2,
    ST_DECIDE  = 4'd3,
    ST_ANALYZE = 4'd4,
    ST_BKT     = 4'd5,
    ST_UPD_SAT = 4'd6,
    ST_UPD_BKT = 4'd7,
    ST_SAT     = 4'd8,
    ST_UNSAT   = 4'd9,
    ST_ERROR   = 4'd10
  } state_e;

  // States that wait on a done_*_i handshake and are covered by the watchdog
  function automatic logic is_wait_state(input state_e s);
    logic w;
    w = 1'b0;
    case (s)
      ST_LOAD, ST_BCP, ST_DECIDE, ST_ANALYZE,
      ST_BKT, ST_UPD_SAT, ST_UPD_BKT: w = 1'b1;
      default:                        w = 1'b0;
    endcase
    return w;
  endfunction

  // States in which a new start_i is accepted
  function automatic logic is_idle_or_terminal(input state_e s);
    logic t;
    t = 1'b0;
    case (s)
      ST_IDLE, ST_SAT, ST_UNSAT, ST_ERROR: t = 1'b1;
      default:                             t = 1'b0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_watchdog.sv
`default_nettype none
// ============================================================================
// Module : phase_watchdog
// Brief  : Cycle counter for one handshake phase. Cleared by the owner on
//          every phase change; flags expiry in the cycle in which the count
//          would step onto its terminal value (2^TMO_W-1).
// Rev    : 1.0  initial release
// ============================================================================
module phase_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] c_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] c_TERM = {TMO_W{1'b1}};

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Restart on clear, otherwise advance and park at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != c_TERM) begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  // Count register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends on the registered count only, so the owner may feed its
  // next-state decision back into clear_i without forming a loop.
  assign expire_o = (cnt_q == (c_TERM - c_ONE));

endmodule
`default_nettype wire

// File: rtl/bin_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bin_sched_ctrl
// Brief  : Top-level scheduler of a bin-partitioned SAT solve. Sequences
//          load / BCP / decision / conflict analysis / backtrack / write-back
//          phases through pulse-and-done handshakes, tracks consecutive
//          satisfied bins and counts conflicts. A phase watchdog forces
//          ERROR when a handshake stalls.
// Rev    : 1.0  initial release
// ============================================================================
module bin_sched_ctrl
  import sat_ctrl_pkg::*;
#(
  parameter int BIN_W = c_BIN_W_DEF,
  parameter int CNT_W = c_CNT_W_DEF,
  parameter int TMO_W = c_TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] total_bin_num_i,
  output logic             done_o,
  output logic             sat_o,
  output logic             unsat_o,
  output logic             error_o,
  output logic             start_load_o,
  output logic [BIN_W-1:0] load_bin_num_o,
  input  logic             done_load_i,
  output logic             start_bcp_o,
  input  logic             done_bcp_i,
  input  logic             conflict_i,
  output logic             start_decision_o,
  input  logic             done_decision_i,
  input  logic             all_assigned_i,
  output logic             start_analyze_o,
  input  logic             done_analyze_i,
  input  logic [BIN_W-1:0] bkt_bin_num_i,
  input  logic             global_unsat_i,
  output logic             start_backtrack_o,
  input  logic             done_backtrack_i,
  output logic             start_update_o,
  input  logic             done_update_i,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam logic [BIN_W-1:0] c_BIN_ONE = BIN_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q,   state_d;
  logic             first_q,   first_d;
  logic [BIN_W-1:0] bin_q,     bin_d;
  logic [BIN_W-1:0] sat_run_q, sat_run_d;
  logic [BIN_W-1:0] total_q,   total_d;
  logic [BIN_W-1:0] tgt_q,     tgt_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic             w_live;
  logic             w_wd_clear;
  logic             w_wd_expire;
  logic             w_pulse_en;
  logic [BIN_W-1:0] w_sat_run_inc;

  // The entry cycle of a phase carries the start pulse; done is only
  // honoured from the following cycle onwards.
  assign w_live        = ~first_q;
  assign w_sat_run_inc = sat_run_q + c_BIN_ONE;

  // Next-state and datapath updates for every phase
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    sat_run_d = sat_run_q;
    total_d   = total_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE, ST_SAT, ST_UNSAT, ST_ERROR: begin
        if (start_i) begin
          total_d   = total_bin_num_i;
          bin_d     = '0;
          sat_run_d = '0;
          tgt_d     = '0;
          cnt_d     = '0;
          state_d   = (total_bin_num_i == '0) ? ST_SAT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_live && done_load_i) begin
          state_d = ST_BCP;
        end
      end
      ST_BCP: begin
        if (w_live && done_bcp_i) begin
          if (conflict_i) begin
            state_d = ST_ANALYZE;
            if (cnt_q != c_CNT_MAX) begin
              cnt_d = cnt_q + c_CNT_ONE;
            end
          end else begin
            state_d = ST_DECIDE;
          end
        end
      end
      ST_DECIDE: begin
        if (w_live && done_decision_i) begin
          state_d = all_assigned_i ? ST_UPD_SAT : ST_BCP;
        end
      end
      ST_ANALYZE: begin
        if (w_live && done_analyze_i) begin
          if (global_unsat_i) begin
            state_d = ST_UNSAT;
          end else begin
            tgt_d   = bkt_bin_num_i;
            state_d = (bkt_bin_num_i == bin_q) ? ST_BKT : ST_UPD_BKT;
          end
        end
      end
      ST_BKT: begin
        if (w_live && done_backtrack_i) begin
          sat_run_d = '0;
          state_d   = ST_BCP;
        end
      end
      ST_UPD_SAT: begin
        if (w_live && done_update_i) begin
          sat_run_d = w_sat_run_inc;
          if (w_sat_run_inc == total_q) begin
            state_d = ST_SAT;
          end else begin
            bin_d   = (bin_q == (total_q - c_BIN_ONE)) ? '0 : (bin_q + c_BIN_ONE);
            state_d = ST_LOAD;
          end
        end
      end
      ST_UPD_BKT: begin
        if (w_live && done_update_i) begin
          if (tgt_q >= total_q) begin
            state_d = ST_ERROR;
          end else begin
            bin_d     = tgt_q;
            sat_run_d = '0;
            state_d   = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled handshake overrides whatever the phase would have done
    if (w_wd_expire && is_wait_state(state_q)) begin
      state_d = ST_ERROR;
    end

    first_d = (state_d != state_q);
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      first_q   <= 1'b0;
      bin_q     <= '0;
      sat_run_q <= '0;
      total_q   <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      bin_q     <= bin_d;
      sat_run_q <= sat_run_d;
      total_q   <= total_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
    end
  end

  // Restart the phase timer on every state change and keep it idle
  // outside the handshake states.
  assign w_wd_clear = (state_d != state_q) || !is_wait_state(state_q);

  phase_watchdog #(
    .TMO_W (TMO_W)
  ) u_phase_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_wd_clear),
    .expire_o (w_wd_expire)
  );

  // Pulses are suppressed while reset is held so none leak from a phase
  // that is being aborted.
  assign w_pulse_en        = first_q & rst;
  assign start_load_o      = w_pulse_en & (state_q == ST_LOAD);
  assign start_bcp_o       = w_pulse_en & (state_q == ST_BCP);
  assign start_decision_o  = w_pulse_en & (state_q == ST_DECIDE);
  assign start_analyze_o   = w_pulse_en & (state_q == ST_ANALYZE);
  assign start_backtrack_o = w_pulse_en & (state_q == ST_BKT);
  assign start_update_o    = w_pulse_en & ((state_q == ST_UPD_SAT) | (state_q == ST_UPD_BKT));

  assign sat_o          = (state_q == ST_SAT);
  assign unsat_o        = (state_q == ST_UNSAT);
  assign error_o        = (state_q == ST_ERROR);
  assign done_o         = sat_o | unsat_o | error_o;
  assign load_bin_num_o = bin_q;
  assign conflict_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_bin_sched_ctrl
// Brief  : Self-checking bench for bin_sched_ctrl. A responder answers each
//          phase pulse from a scripted scenario; a solve-level model walks
//          the same script and predicts the ordered list of phase pulses
//          (kind, bin, conflict count) and the final verdict.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bin_sched_ctrl;

  localparam int TB_BIN_W = 16;
  localparam int TB_CNT_W = 32;
  localparam int TB_TMO_W = 4;

  localparam logic [5:0] M_LOAD = 6'b100000;
  localparam logic [5:0] M_BCP  = 6'b010000;
  localparam logic [5:0] M_DEC  = 6'b001000;
  localparam logic [5:0] M_ANA  = 6'b000100;
  localparam logic [5:0] M_BKT  = 6'b000010;
  localparam logic [5:0] M_UPD  = 6'b000001;

  typedef struct {
    logic [5:0] mask;
    int         bin;
    int         cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start_i = 1'b0;
  logic [TB_BIN_W-1:0] total_bin_num_i = '0;
  logic                done_o, sat_o, unsat_o, error_o;
  logic                start_load_o, start_bcp_o, start_decision_o;
  logic                start_analyze_o, start_backtrack_o, start_update_o;
  logic [TB_BIN_W-1:0] load_bin_num_o;
  logic [TB_CNT_W-1:0] conflict_cnt_o;
  logic                done_load_i = 1'b0, done_bcp_i = 1'b0, conflict_i = 1'b0;
  logic                done_decision_i = 1'b0, all_assigned_i = 1'b0;
  logic                done_analyze_i = 1'b0, global_unsat_i = 1'b0;
  logic [TB_BIN_W-1:0] bkt_bin_num_i = '0;
  logic                done_backtrack_i = 1'b0, done_update_i = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // scenario script shared by responder and model
  bit [15:0] bcp_arr;
  bit [15:0] dec_arr;
  int        ana_tgt;
  bit        ana_gu;
  int        rb, rd;
  int        resp_lat = 1;
  bit        resp_en = 1'b0;
  bit        withhold_bcp = 1'b0;

  // model results and observation counters
  exp_t      exp_q[$];
  logic [2:0] exp_res;
  int        exp_cnt;
  bit        chk_en = 1'b0;
  int        ld_cnt, upd_cnt;

  always #5 clk = ~clk;

  bin_sched_ctrl #(
    .BIN_W (TB_BIN_W),
    .CNT_W (TB_CNT_W),
    .TMO_W (TB_TMO_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .total_bin_num_i   (total_bin_num_i),
    .done_o            (done_o),
    .sat_o             (sat_o),
    .unsat_o           (unsat_o),
    .error_o           (error_o),
    .start_load_o      (start_load_o),
    .load_bin_num_o    (load_bin_num_o),
    .done_load_i       (done_load_i),
    .start_bcp_o       (start_bcp_o),
    .done_bcp_i        (done_bcp_i),
    .conflict_i        (conflict_i),
    .start_decision_o  (start_decision_o),
    .done_decision_i   (done_decision_i),
    .all_assigned_i    (all_assigned_i),
    .start_analyze_o   (start_analyze_o),
    .done_analyze_i    (done_analyze_i),
    .bkt_bin_num_i     (bkt_bin_num_i),
    .global_unsat_i    (global_unsat_i),
    .start_backtrack_o (start_backtrack_o),
    .done_backtrack_i  (done_backtrack_i),
    .start_update_o    (start_update_o),
    .done_update_i     (done_update_i),
    .conflict_cnt_o    (conflict_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [5:0] m, input int b, input int c);
    exp_t e;
    e.mask = m;
    e.bin  = b;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  task automatic set_scn(input bit [15:0] b, input bit [15:0] d, input int t, input bit g);
    bcp_arr = b;
    dec_arr = d;
    ana_tgt = t;
    ana_gu  = g;
  endtask

  // Solve-level model: walk the script as the solver algorithm would and
  // record every phase that must be started, in order.
  task automatic model(input int total);
    int  bin, sat_run, cnt, ib, id, guard;
    bit  fin, need_load;
    exp_q.delete();
    bin = 0; sat_run = 0; cnt = 0; ib = 0; id = 0; guard = 0;
    exp_res = 3'b000;
    if (total == 0) begin
      exp_res = 3'b100;
      exp_cnt = 0;
      return;
    end
    fin = 1'b0;
    need_load = 1'b1;
    while (!fin && guard < 64) begin
      guard++;
      if (need_load) push(M_LOAD, bin, cnt);
      need_load = 1'b0;
      push(M_BCP, bin, cnt);
      if (bcp_arr[ib]) begin
        cnt++;
        push(M_ANA, bin, cnt);
        if (ana_gu) begin
          exp_res = 3'b010;
          fin = 1'b1;
        end else if (ana_tgt == bin) begin
          push(M_BKT, bin, cnt);
          sat_run = 0;
        end else begin
          push(M_UPD, bin, cnt);
          if (ana_tgt >= total) begin
            exp_res = 3'b001;
            fin = 1'b1;
          end else begin
            bin = ana_tgt;
            sat_run = 0;
            need_load = 1'b1;
          end
        end
      end else begin
        push(M_DEC, bin, cnt);
        if (dec_arr[id]) begin
          push(M_UPD, bin, cnt);
          sat_run++;
          if (sat_run == total) begin
            exp_res = 3'b100;
            fin = 1'b1;
          end else begin
            bin = (bin + 1) % total;
            need_load = 1'b1;
          end
        end
        id++;
      end
      ib++;
    end
    exp_cnt = cnt;
  endtask

  // Responder: answers each pulse resp_lat cycles later from the script
  initial begin : responder
    logic [5:0] pv;
    forever begin
      @(negedge clk);
      pv = {start_load_o, start_bcp_o, start_decision_o,
            start_analyze_o, start_backtrack_o, start_update_o};
      if (resp_en && rst && pv != 6'b0) begin
        repeat (resp_lat) @(posedge clk);
        #1;
        if (resp_en && rst) begin
          if (pv[5]) done_load_i = 1'b1;
          if (pv[4] && !withhold_bcp) begin
            done_bcp_i = 1'b1;
            conflict_i = bcp_arr[rb];
            rb++;
          end
          if (pv[3]) begin
            done_decision_i = 1'b1;
            all_assigned_i  = dec_arr[rd];
            rd++;
          end
          if (pv[2]) begin
            done_analyze_i = 1'b1;
            bkt_bin_num_i  = ana_tgt[TB_BIN_W-1:0];
            global_unsat_i = ana_gu;
          end
          if (pv[1]) done_backtrack_i = 1'b1;
          if (pv[0]) done_update_i = 1'b1;
        end
        @(posedge clk);
        #1;
        done_load_i = 1'b0; done_bcp_i = 1'b0; conflict_i = 1'b0;
        done_decision_i = 1'b0; all_assigned_i = 1'b0;
        done_analyze_i = 1'b0; global_unsat_i = 1'b0; bkt_bin_num_i = '0;
        done_backtrack_i = 1'b0; done_update_i = 1'b0;
      end
    end
  end

  // Compare process: every phase pulse must be the next one the model predicts
  initial begin : compare
    logic [5:0] pv;
    exp_t       e;
    forever begin
      @(negedge clk);
      pv = {start_load_o, start_bcp_o, start_decision_o,
            start_analyze_o, start_backtrack_o, start_update_o};
      if (chk_en && pv != 6'b0) begin
        if (start_load_o) ld_cnt++;
        if (start_update_o) upd_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pulse: got mask=%b bin=%0d want no pulse", pv, load_bin_num_o);
        end else begin
          e = exp_q.pop_front();
          if (pv !== e.mask || load_bin_num_o !== e.bin[TB_BIN_W-1:0] ||
              conflict_cnt_o !== TB_CNT_W'(e.cnt) || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse: got mask=%b bin=%0d cnt=%0d done=%b want mask=%b bin=%0d cnt=%0d done=0",
                     pv, load_bin_num_o, conflict_cnt_o, done_o, e.mask, e.bin, e.cnt);
          end
        end
      end
    end
  end

  // One full solve: start, optionally poke start_i mid-run, then verdict
  task automatic run_case(input string nm, input int total, input int lat, input bit poke);
    bit got;
    model(total);
    rb = 0; rd = 0; ld_cnt = 0; upd_cnt = 0;
    resp_lat = lat; resp_en = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    total_bin_num_i = total[TB_BIN_W-1:0];
    @(posedge clk); #1;
    start_i = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      if (poke && cyc == 3) begin
        start_i = 1'b1;
        total_bin_num_i = '0;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      if (done_o) got = 1'b1;
    end
    start_i = 1'b0;
    chk({nm, " done"}, 64'(got), 64'd1);
    chk({nm, " verdict"}, 64'({sat_o, unsat_o, error_o}), 64'(exp_res));
    chk({nm, " conflicts"}, 64'(conflict_cnt_o), 64'(exp_cnt));
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " pulses left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : global_bound
    #300000;
    $display("FAIL global time limit: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    bit got;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs",
        {done_o, sat_o, unsat_o, error_o, start_load_o, start_bcp_o, start_decision_o,
         start_analyze_o, start_backtrack_o, start_update_o, load_bin_num_o, conflict_cnt_o},
        64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // total = 0 completes as SAT with no phase pulses
    exp_q.delete();
    chk_en = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    total_bin_num_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("total0 flags", 64'({done_o, sat_o, unsat_o, error_o}), 64'b1100);

    // single bin satisfied on first pass
    set_scn(16'h0000, 16'h0001, 0, 1'b0);
    run_case("one bin", 1, 1, 1'b0);
    chk("one bin literal", 64'({done_o, sat_o, conflict_cnt_o}), {30'd0, 2'b11, 32'd0});

    // three bins satisfied in turn, start_i mid-run ignored
    set_scn(16'h0000, 16'h0007, 0, 1'b0);
    run_case("three bins", 3, 2, 1'b1);
    chk("three bins loads", 64'(ld_cnt), 64'd3);

    // conflict in bin1 sends the solve back to bin0
    set_scn(16'h0002, 16'h0007, 0, 1'b0);
    run_case("backjump", 2, 1, 1'b0);
    chk("backjump conflicts", 64'(conflict_cnt_o), 64'd1);
    chk("backjump loads", 64'(ld_cnt), 64'd4);

    // undecided decision loops to BCP, local backtrack in same bin
    set_scn(16'h0002, 16'h0006, 0, 1'b0);
    run_case("local bkt", 2, 3, 1'b1);

    // global UNSAT wins even though the target differs from the bin
    set_scn(16'h0002, 16'h0001, 0, 1'b1);
    run_case("unsat", 3, 2, 1'b0);
    chk("unsat updates", 64'(upd_cnt), 64'd1);
    chk("unsat literal", 64'({done_o, unsat_o}), 64'b11);

    // backtrack target outside the bin range
    set_scn(16'h0001, 16'h0000, 5, 1'b0);
    run_case("bad target", 2, 1, 1'b0);
    chk("bad target literal", 64'({done_o, error_o, sat_o}), 64'b110);

    // jump to last bin then wrap to bin 0
    set_scn(16'h0001, 16'h0003, 1, 1'b0);
    run_case("wrap", 2, 2, 1'b0);
    chk("wrap loads", 64'(ld_cnt), 64'd3);

    // watchdog: BCP never answers; pulse cycle is cycle 0 of the wait
    chk_en = 1'b0;
    set_scn(16'h0000, 16'h0001, 0, 1'b0);
    rb = 0; rd = 0; resp_lat = 1; resp_en = 1'b1; withhold_bcp = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    total_bin_num_i = 16'd1;
    @(posedge clk); #1;
    start_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (start_bcp_o) got = 1'b1;
    end
    chk("tmo bcp pulse", 64'(got), 64'd1);
    repeat (14) @(negedge clk);
    chk("tmo cycle14", 64'({done_o, error_o}), 64'b00);
    @(negedge clk);
    chk("tmo cycle15", 64'({done_o, error_o, sat_o, unsat_o}), 64'b1100);
    withhold_bcp = 1'b0;

    // reset asserted while DECIDE awaits its done
    set_scn(16'h0001, 16'h0003, 1, 1'b0);
    model(2);
    rb = 0; rd = 0; resp_lat = 2; resp_en = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    total_bin_num_i = 16'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (start_decision_o) got = 1'b1;
    end
    chk("rst decide reached", 64'({got, conflict_cnt_o}), {31'd0, 1'b1, 32'd1});
    @(posedge clk); #1;
    chk_en = 1'b0;
    resp_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst cycle pulses",
        64'({start_load_o, start_bcp_o, start_decision_o,
             start_analyze_o, start_backtrack_o, start_update_o}), 64'd0);
    @(negedge clk);
    chk("rst outputs",
        {done_o, sat_o, unsat_o, error_o, start_load_o, start_bcp_o, start_decision_o,
         start_analyze_o, start_backtrack_o, start_update_o, load_bin_num_o, conflict_cnt_o},
        64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post release", 64'({done_o, start_load_o, start_bcp_o, start_decision_o,
                             start_analyze_o, start_backtrack_o, start_update_o}), 64'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);

    // clean solve after reset
    set_scn(16'h0000, 16'h0001, 0, 1'b0);
    run_case("after rst", 1, 1, 1'b0);
    chk("after rst loads", 64'(ld_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
